// File: rtl/mem_pkg.sv
// Shared types and default constants for the RAM-backed stack controller.
// Holds the controller state encoding and parameter defaults.
`timescale 1ns/1ps
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2
    } stk_state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_RD_LAT     = 2;

    // Width of a down-counter that must hold the value lat.
    function automatic int lat_cnt_width(input int lat);
        return (lat < 2) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/ram_stack_ctrl.sv
// LIFO stack controller driving an external single-port RAM.
// Optional sticky error flags: define RAM_STACK_ERR_EN.
`timescale 1ns/1ps
module ram_stack_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RD_LAT     = DEF_RD_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_ready,
    input  logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_rvalid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we_n,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    input  logic                  err_clr,
    output logic                  err_ovf,
    output logic                  err_unf
);

    localparam int LW = lat_cnt_width(RD_LAT);
    localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = 1;
    localparam logic [LW-1:0]       LAT_INIT = LW'(RD_LAT);
    localparam logic [LW-1:0]       LAT_ONE  = 1;

    stk_state_e            state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  we_n_q, we_n_d;
    logic [LW-1:0]         lat_q, lat_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  rvalid_q, rvalid_d;

    logic                  push_acc;
    logic                  pop_acc;
    logic [ADDR_WIDTH:0]   count_m1;

    assign push_ready = (state_q == IDLE);
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_FULL);
    assign count      = count_q;
    assign ram_addr   = addr_q;
    assign ram_din    = din_q;
    assign ram_we_n   = we_n_q;
    assign pop_data   = pdata_q;
    assign pop_rvalid = rvalid_q;

    // Push wins a tie; a pop only goes when no push is taken.
    assign push_acc = push_valid & push_ready & ~full;
    assign pop_acc  = pop_valid & push_ready & ~empty & ~push_acc;
    assign count_m1 = count_q - CNT_ONE;

    // Controller state and RAM-side registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            addr_q   <= '0;
            din_q    <= '0;
            we_n_q   <= 1'b1;
            lat_q    <= '0;
            pdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            we_n_q   <= we_n_d;
            lat_q    <= lat_d;
            pdata_q  <= pdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Next-state: accept in IDLE, one-cycle write strobe, timed read capture.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        addr_d   = addr_q;
        din_d    = din_q;
        we_n_d   = 1'b1;
        lat_d    = lat_q;
        pdata_d  = pdata_q;
        rvalid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (push_acc) begin
                    addr_d  = count_q[ADDR_WIDTH-1:0];
                    din_d   = push_data;
                    we_n_d  = 1'b0;
                    state_d = WRITE;
                end else if (pop_acc) begin
                    count_d = count_m1;
                    addr_d  = count_m1[ADDR_WIDTH-1:0];
                    lat_d   = LAT_INIT;
                    state_d = READ_WAIT;
                end
            end
            WRITE: begin
                count_d = count_q + CNT_ONE;
                state_d = IDLE;
            end
            READ_WAIT: begin
                if (lat_q == '0) begin
                    pdata_d  = ram_dout;
                    rvalid_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    lat_d = lat_q - LAT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef RAM_STACK_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // Sticky error flags; a clear request beats a same-cycle set.
    always_comb begin
        ovf_d = ovf_q | (push_valid & push_ready & full);
        unf_d = unf_q | (pop_valid & push_ready & empty);
        if (err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign err_ovf = ovf_q;
    assign err_unf = unf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_ovf = 1'b0;
    assign err_unf = 1'b0;
`endif

endmodule
